// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and muldiv_unit.
// Master drives in_valid/op/a/b; the unit answers with in_ready, out_valid, result.
// Ports: in_valid, in_ready, op[2:0], a/b[XLEN-1:0], out_valid, result[XLEN-1:0].
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op, a, b,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, a, b,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiplier, restoring divider.
// Latency: out_valid at accept+XLEN+1 edges (accept+1 for div-by-zero/overflow), one-cycle pulse.
// Backpressure: in_ready high only in IDLE; one operation in flight, result is not held off.
// Ports: clk, rst_n (async active-low), flush (sync abort), bus (muldiv_unit_if.slave).
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;     // {hi/remainder, lo/multiplier-quotient}
  logic              qneg_q, qneg_d;   // product or quotient sign
  logic              rneg_q, rneg_d;   // remainder sign
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              out_valid_q, out_valid_d;

  // Operand decode at the accept edge
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;
  logic            div_zero, div_ovf, bypass;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (bus.op)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'b010:  a_sgn = 1'b1;
      default: ;
    endcase
    a_neg = a_sgn & bus.a[XLEN-1];
    b_neg = b_sgn & bus.b[XLEN-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;

    div_zero = (bus.b == '0);
    div_ovf  = ((bus.op == 3'b100) || (bus.op == 3'b110)) &&
               (bus.a == MOST_NEG) && (bus.b == ALL_ONES);
    bypass   = bus.op[2] && (div_zero || div_ovf);
    // op[1] separates REM/REMU from DIV/DIVU
    spec_res = '0;
    if (div_zero) spec_res = bus.op[1] ? bus.a : ALL_ONES;
    else if (div_ovf) spec_res = bus.op[1] ? '0 : bus.a;
  end

  // One iteration of each datapath
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;
  logic              div_ok;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opb_q};
    div_ok    = ~div_diff[XLEN];
    div_next  = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                 acc_q[XLEN-2:0], div_ok};
  end

  // Sign correction and result selection
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fin;

  always_comb begin
    prod = qneg_q ? -acc_q : acc_q;
    quo  = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:         fin = prod[XLEN-1:0];
      3'b100, 3'b101: fin = quo;
      3'b110, 3'b111: fin = rem;
      default:        fin = prod[2*XLEN-1:XLEN];
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && !flush) begin
          state_d = S_CALC;
          op_d    = bus.op;
          opb_d   = b_mag;
          acc_d   = {{XLEN{1'b0}}, a_mag};
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          cnt_d   = '0;
          if (bypass) begin
            // Park the special value in both halves with no sign fix-up and a
            // full count: the next edge finalises it without iterating.
            acc_d  = {spec_res, spec_res};
            qneg_d = 1'b0;
            rneg_d = 1'b0;
            cnt_d  = CW'(XLEN);
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(XLEN)) begin
          state_d     = S_DONE;
          result_d    = fin;
          out_valid_d = 1'b1;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised RV32M-style multiply/divide unit, the multi-cycle companion to the core's single-cycle integer ALU. It accepts one operation at a time through a valid/ready handshake. It computes the result with a radix-2 shift-add multiplier or a restoring divider, one bit per cycle, and presents the result with a one-cycle valid pulse. The execute stage stalls on `in_ready`/`out_valid` while an M-extension instruction is in flight.

## Interface
- `XLEN`, default 32: operand and result width. Must be an even number ≥ 4. The iteration counter is clog2(XLEN+1) bits.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous abort of the operation in flight.
- `in_valid` input 1: request valid.
- `in_ready` output 1: unit can accept. Combinational, high only in IDLE.
- `op` input 3: operation, using RISC-V funct3 encoding.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a` input XLEN: rs1 operand.
- `b` input XLEN: rs2 operand.
- `out_valid` output 1: one-cycle pulse when `result` is new.
- `result` output XLEN: registered result. Holds its value until the next completion.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - CALC: iterating, `in_ready`=0.
  - DONE: `out_valid`=1, `in_ready`=0.
- Accept: `in_valid && in_ready` at a rising edge.
  - `op`, `a` and `b` are captured.
  - Signed operands are converted to magnitudes.
  - The result sign is recorded: quotient sign = sign(a)^sign(b); remainder sign = sign(a); product sign per op.
  - Iteration count is cleared. State moves to CALC.
  - `a` and `b` are ignored outside the accept edge.
- Signedness per op:
  - MUL and MULH: a and b signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: a and b unsigned.
  - DIV and REM: a and b signed.
- Multiply:
  - 2·XLEN-bit accumulator. Each CALC cycle conditionally adds the multiplicand, then shifts.
  - After XLEN iterations the product is negated if the product sign is set.
  - MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits.
- Divide:
  - Restoring algorithm. Each iteration shifts the partial remainder and trial-subtracts the divisor magnitude.
  - The quotient bit is set when the subtraction does not borrow.
  - After XLEN iterations the quotient and remainder are sign-corrected.
- Special cases are detected at accept and bypass CALC, going straight to DONE:
  - Divide by zero (b=0): DIV and DIVU return all-ones; REM and REMU return a.
  - Signed overflow (DIV/REM with a=most-negative, b=all-ones): DIV returns a; REM returns 0.
- CALC to DONE: after XLEN iterations plus one sign-correction edge. `result` and `out_valid` are registered on that edge.
- DONE to IDLE: unconditional on the next edge. `out_valid` drops.
- `flush`:
  - In CALC or DONE: the next edge goes to IDLE. `out_valid` is 0 on that edge, and if it was high it is cleared. `result` is not updated.
  - In IDLE with `in_valid` high: flush wins and nothing is accepted.
- Reset:
  - Every state on `rst_n` low: immediate return to IDLE, with `result`=0, `out_valid`=0 and iteration count 0.
  - `in_ready` reads 1 during reset. Any in-flight operation is discarded.

## Timing
- Normal latency:
  - The accept edge is E0. E0 loads the operands.
  - Edges E1..E(XLEN) each perform one iteration.
  - E(XLEN+1) sign-corrects and raises `out_valid`. For XLEN=32 this is edge 33.
- Bypass latency: `out_valid` rises at E1.
- `out_valid` is high for exactly one cycle.
- `in_ready` rises at the edge where `out_valid` falls: E(XLEN+2) normally, E2 on bypass.
- The next accept is possible at the following edge. Back-to-back throughput is XLEN+3 cycles per op (3 on bypass).
- `result` changes only on the edge that raises `out_valid`.

## Test plan
- Multiply, each with `out_valid` at E33 and for one cycle only:
  - MUL 7×0xFFFFFFFD -> 0xFFFFFFEB.
  - MULH of the same operands -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Divide:
  - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
  - REM of the same operands -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
- Divide by zero:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - `out_valid` at E1 and `in_ready` back at E2.
- Overflow:
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0, via bypass.
- Flush and reset:
  - `flush` during the 10th CALC cycle -> no `out_valid`, `result` unchanged, `in_ready`=1 after the next edge. A following MULHU returns the correct value.
  - `rst_n` pulsed low mid-CALC -> `result`=0, `out_valid`=0 and `in_ready`=1 immediately.
- Back-to-back:
  - Hold `in_valid` high with changing operands -> accepts exactly 35 edges apart.
  - Operands presented while busy never affect results.
  - A flush asserted together with `in_valid` in IDLE -> no accept.
